// File: rtl/arm_multicycle_ctrl.sv
// Multicycle ARM control unit: main FSM, ALU-control decode, condition gating
// of architectural writes and a retired-instruction counter.
module arm_multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       Op,
  input  logic [5:0]       Funct,
  input  logic [3:0]       Rd,
  input  logic             CondEx,
  input  logic             mem_ready,
  output logic             IRWrite,
  output logic             AdrSrc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ImmSrc,
  output logic [1:0]       RegSrc,
  output logic [2:0]       ALUControl,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [1:0]       FlagWrite,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXECR  = 4'd6;
  localparam logic [3:0] S_EXECI  = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;

  logic [3:0] state, state_nxt;
  logic       regw, memw, branch, nextpc, aluop;
  logic       retire_c, illegal_c, pcs;
  logic [1:0] flagw;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_nxt;
  end

  // Retirement counter and illegal-opcode pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_count <= '0;
      illegal_op  <= 1'b0;
    end else begin
      illegal_op <= illegal_c;
      if (retire_c) instr_count <= instr_count + CNT_W'(1);
    end
  end

  // Next state and Moore controls
  always_comb begin
    state_nxt = state;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    regw      = 1'b0;
    memw      = 1'b0;
    branch    = 1'b0;
    nextpc    = 1'b0;
    aluop     = 1'b0;
    illegal_c = 1'b0;
    case (state)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_ready) begin
          IRWrite   = 1'b1;
          nextpc    = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (Op)
          2'b00:   state_nxt = Funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_nxt = S_MEMADR;
          2'b10:   state_nxt = S_BRANCH;
          default: begin
            illegal_c = 1'b1;
            state_nxt = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcB   = 2'b01;
        state_nxt = Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        regw      = 1'b1;
        state_nxt = S_FETCH;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        memw   = 1'b1;
        // A failed condition drops the store without waiting on memory
        if (!CondEx || mem_ready) state_nxt = S_FETCH;
      end
      S_EXECR: begin
        aluop     = 1'b1;
        state_nxt = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcB   = 2'b01;
        aluop     = 1'b1;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        regw      = (Funct[4:1] != 4'b1010);
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  assign retire_c = (state_nxt == S_FETCH) &&
                    ((state == S_MEMWB) || (state == S_MEMWR) ||
                     (state == S_ALUWB) || (state == S_BRANCH));

  // ALU-control decode
  always_comb begin
    ALUControl = 3'b000;
    flagw      = 2'b00;
    if (aluop) begin
      case (Funct[4:1])
        4'b0100: ALUControl = 3'b000;
        4'b0010: ALUControl = 3'b001;
        4'b0000: ALUControl = 3'b010;
        4'b1100: ALUControl = 3'b011;
        4'b1010: ALUControl = 3'b001;
        4'b1101: ALUControl = 3'b100;
        default: ALUControl = 3'b000;
      endcase
      flagw = {Funct[0], Funct[0] & ((ALUControl == 3'b000) || (ALUControl == 3'b001))};
    end
  end

  assign ImmSrc = Op;
  assign RegSrc = {(Op == 2'b01) & ~Funct[0], (Op == 2'b10)};

  // Condition gating; a write to R15 becomes a PC update
  assign pcs       = (Rd == 4'b1111) & regw;
  assign RegWrite  = regw & CondEx & ~pcs;
  assign MemWrite  = memw & CondEx;
  assign FlagWrite = flagw & {2{CondEx}};
  assign PCWrite   = nextpc | ((branch | pcs) & CondEx);

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Bench for arm_multicycle_ctrl: directed instruction table, random instruction
// stream against a trace-based reference model, reset and counter-wrap sequences.
module tb_arm_multicycle_ctrl;

  logic       clk, reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       CondEx, mem_ready;

  logic       IRWrite, AdrSrc, ALUSrcA, PCWrite, RegWrite, MemWrite, illegal_op;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, FlagWrite;
  logic [2:0] ALUControl;
  logic [31:0] instr_count;

  logic       s_irw, s_adr, s_sa, s_pcw, s_rw, s_mw, s_ill;
  logic [1:0] s_sb, s_rs, s_is, s_rsrc, s_fw;
  logic [2:0] s_alu;
  logic [2:0] instr_count_s;

  arm_multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .CondEx(CondEx),
    .mem_ready(mem_ready), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .ALUControl(ALUControl), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .FlagWrite(FlagWrite), .illegal_op(illegal_op),
    .instr_count(instr_count)
  );

  // Narrow-counter copy on the same stimulus, used to observe wraparound
  arm_multicycle_ctrl #(.CNT_W(3)) dut_s (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .CondEx(CondEx),
    .mem_ready(mem_ready), .IRWrite(s_irw), .AdrSrc(s_adr), .ALUSrcA(s_sa),
    .ALUSrcB(s_sb), .ResultSrc(s_rs), .ImmSrc(s_is), .RegSrc(s_rsrc),
    .ALUControl(s_alu), .PCWrite(s_pcw), .RegWrite(s_rw),
    .MemWrite(s_mw), .FlagWrite(s_fw), .illegal_op(s_ill),
    .instr_count(instr_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef enum int {P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_ER, P_EI, P_AWB, P_BR} ph_t;
  typedef struct { ph_t ph; logic rdy; } step_t;
  typedef struct {
    logic [1:0] op; logic [5:0] f; logic [3:0] rd; logic ce;
    int fw; int mw; int cycles; int regw; int memw; int pcw;
    logic [1:0] flg; logic [2:0] alu; int dcount;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] mcount = '0;
  logic pend_ill = 1'b0;
  step_t q[$];
  int a_regw, a_memw, a_pcw, a_irw;
  logic [1:0] a_flg;
  logic [2:0] a_alu;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] e);
    vectors++;
    if (act !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, e, $time);
    end
  endtask

  // Expected combinational controls for one cycle of a given phase
  function automatic logic [18:0] exp_out(ph_t ph, logic [1:0] op, logic [5:0] f,
                                          logic [3:0] rd, logic ce, logic rdy);
    logic irw, adr, sa, regw, memw, br, npc, aluop, pcs;
    logic [1:0] sb, rs, fw;
    logic [2:0] alu;
    irw = 0; adr = 0; sa = 0; regw = 0; memw = 0; br = 0; npc = 0; aluop = 0;
    sb = 2'b00; rs = 2'b00; fw = 2'b00; alu = 3'b000;
    case (ph)
      P_F:   begin sa = 1; sb = 2'b10; rs = 2'b10; irw = rdy; npc = rdy; end
      P_D:   begin sa = 1; sb = 2'b10; rs = 2'b10; end
      P_MA:  sb = 2'b01;
      P_MR:  adr = 1;
      P_MWB: begin rs = 2'b01; regw = 1; end
      P_MW:  begin adr = 1; memw = 1; end
      P_ER:  aluop = 1;
      P_EI:  begin sb = 2'b01; aluop = 1; end
      P_AWB: regw = (f[4:1] != 4'b1010);
      P_BR:  begin sb = 2'b01; rs = 2'b10; br = 1; end
      default: ;
    endcase
    if (aluop) begin
      case (f[4:1])
        4'b0100: alu = 3'd0;
        4'b0010: alu = 3'd1;
        4'b0000: alu = 3'd2;
        4'b1100: alu = 3'd3;
        4'b1010: alu = 3'd1;
        4'b1101: alu = 3'd4;
        default: alu = 3'd0;
      endcase
      fw = {f[0], f[0] & (alu <= 3'd1)};
    end
    pcs = (rd == 4'd15) && regw;
    return {irw, adr, sa, sb, rs, op, (op == 2'b01) && !f[0], (op == 2'b10), alu,
            npc | ((br | pcs) & ce), regw & ce & !pcs, memw & ce, fw & {2{ce}}};
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected per-cycle phase sequence of one instruction and the ready values to drive
  task automatic build(input logic [1:0] op, input logic [5:0] f, input logic ce,
                       input int fw, input int mw);
    q.delete();
    repeat (fw) q.push_back('{ph: P_F, rdy: 1'b0});
    q.push_back('{ph: P_F, rdy: 1'b1});
    q.push_back('{ph: P_D, rdy: rnd()});
    case (op)
      2'b00: begin
        q.push_back('{ph: (f[5] ? P_EI : P_ER), rdy: rnd()});
        q.push_back('{ph: P_AWB, rdy: rnd()});
      end
      2'b01: begin
        q.push_back('{ph: P_MA, rdy: rnd()});
        if (f[0]) begin
          repeat (mw) q.push_back('{ph: P_MR, rdy: 1'b0});
          q.push_back('{ph: P_MR, rdy: 1'b1});
          q.push_back('{ph: P_MWB, rdy: rnd()});
        end else if (ce) begin
          repeat (mw) q.push_back('{ph: P_MW, rdy: 1'b0});
          q.push_back('{ph: P_MW, rdy: 1'b1});
        end else begin
          q.push_back('{ph: P_MW, rdy: (mw > 0) ? 1'b0 : 1'b1});
        end
      end
      2'b10: q.push_back('{ph: P_BR, rdy: rnd()});
      default: ;
    endcase
  endtask

  task automatic do_cycle(input step_t s, input logic [1:0] op, input logic [5:0] f,
                          input logic [3:0] rd, input logic ce, input int idx, input int alu_idx);
    logic [18:0] e, a;
    @(negedge clk);
    Op = op; Funct = f; Rd = rd; CondEx = ce; mem_ready = s.rdy;
    #1;
    e = exp_out(s.ph, op, f, rd, ce, s.rdy);
    a = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl,
         PCWrite, RegWrite, MemWrite, FlagWrite};
    chk($sformatf("ctrl[ph%0d]", int'(s.ph)), 32'(a), 32'(e));
    chk("count", instr_count, mcount);
    chk("count_s", 32'(instr_count_s), 32'(mcount[2:0]));
    chk("illegal", 32'(illegal_op), 32'((idx == 0) && pend_ill));
    if (idx == 0) pend_ill = 1'b0;
    a_regw += int'(RegWrite);
    a_memw += int'(MemWrite);
    a_pcw  += int'(PCWrite);
    a_irw  += int'(IRWrite);
    a_flg  |= FlagWrite;
    if (idx == alu_idx) a_alu = ALUControl;
  endtask

  task automatic run_instr(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                           input logic ce, input int fw, input int mw, output int n);
    build(op, f, ce, fw, mw);
    a_regw = 0; a_memw = 0; a_pcw = 0; a_irw = 0; a_flg = 2'b00; a_alu = 3'b000;
    for (int i = 0; i < q.size(); i++) do_cycle(q[i], op, f, rd, ce, i, fw + 2);
    n = q.size();
    if (op == 2'b11) pend_ill = 1'b1;
    else             mcount   = mcount + 32'd1;
  endtask

  vec_t tbl[15];
  logic [3:0] cmds[6];

  initial begin
    int n;
    logic [31:0] c0;
    //          op     f          rd  ce fw mw cyc rw mw pcw flg    alu    dc
    tbl[0]  = '{2'b00, 6'b101000, 4'd2,  1, 0, 0, 4, 1, 0, 1, 2'b00, 3'd0, 1}; // ADD imm
    tbl[1]  = '{2'b00, 6'b010101, 4'd0,  1, 0, 0, 4, 0, 0, 1, 2'b11, 3'd1, 1}; // CMP reg
    tbl[2]  = '{2'b01, 6'b011001, 4'd3,  1, 3, 2,10, 1, 0, 1, 2'b00, 3'd0, 1}; // LDR waits
    tbl[3]  = '{2'b01, 6'b011000, 4'd3,  0, 0, 2, 4, 0, 0, 1, 2'b00, 3'd0, 1}; // STR cond fail
    tbl[4]  = '{2'b01, 6'b011000, 4'd3,  1, 1, 2, 7, 0, 3, 1, 2'b00, 3'd0, 1}; // STR waits
    tbl[5]  = '{2'b10, 6'b000000, 4'd0,  1, 0, 0, 3, 0, 0, 2, 2'b00, 3'd0, 1}; // B taken
    tbl[6]  = '{2'b10, 6'b000000, 4'd0,  0, 0, 0, 3, 0, 0, 1, 2'b00, 3'd0, 1}; // B not taken
    tbl[7]  = '{2'b11, 6'b000000, 4'd0,  1, 0, 0, 2, 0, 0, 1, 2'b00, 3'd0, 0}; // illegal
    tbl[8]  = '{2'b00, 6'b001000, 4'd15, 1, 0, 0, 4, 0, 0, 2, 2'b00, 3'd0, 1}; // ADD to PC
    tbl[9]  = '{2'b00, 6'b100101, 4'd6,  0, 0, 0, 4, 0, 0, 1, 2'b00, 3'd1, 1}; // SUBS cond fail
    tbl[10] = '{2'b00, 6'b011001, 4'd4,  1, 0, 0, 4, 1, 0, 1, 2'b10, 3'd3, 1}; // ORRS
    tbl[11] = '{2'b00, 6'b111010, 4'd5,  1, 0, 0, 4, 1, 0, 1, 2'b00, 3'd4, 1}; // MOV imm
    tbl[12] = '{2'b01, 6'b011001, 4'd15, 0, 0, 0, 5, 0, 0, 1, 2'b00, 3'd0, 1}; // LDR PC fail
    tbl[13] = '{2'b00, 6'b000000, 4'd1,  1, 0, 0, 4, 1, 0, 1, 2'b00, 3'd2, 1}; // AND reg
    tbl[14] = '{2'b01, 6'b011001, 4'd15, 1, 0, 0, 5, 0, 0, 2, 2'b00, 3'd0, 1}; // LDR to PC
    cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000;
    cmds[3] = 4'b1100; cmds[4] = 4'b1010; cmds[5] = 4'b1101;

    reset = 1'b0; Op = 2'b00; Funct = '0; Rd = '0; CondEx = 1'b0; mem_ready = 1'b0;
    #3;
    chk("rst_ctrl", 32'({IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc,
        ALUControl, PCWrite, RegWrite, MemWrite, FlagWrite}),
        32'(exp_out(P_F, 2'b00, 6'd0, 4'd0, 1'b0, 1'b0)));
    chk("rst_count", instr_count, 32'd0);
    chk("rst_illegal", 32'(illegal_op), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    foreach (tbl[k]) begin
      c0 = mcount;
      run_instr(tbl[k].op, tbl[k].f, tbl[k].rd, tbl[k].ce, tbl[k].fw, tbl[k].mw, n);
      if (n != tbl[k].cycles) begin
        $display("FAIL table[%0d]: model length %0d vs table %0d", k, n, tbl[k].cycles);
        $fatal(1);
      end
      chk($sformatf("t%0d_regw", k), 32'(a_regw), 32'(tbl[k].regw));
      chk($sformatf("t%0d_memw", k), 32'(a_memw), 32'(tbl[k].memw));
      chk($sformatf("t%0d_pcw", k),  32'(a_pcw),  32'(tbl[k].pcw));
      chk($sformatf("t%0d_irw", k),  32'(a_irw),  32'd1);
      chk($sformatf("t%0d_flg", k),  32'(a_flg),  32'(tbl[k].flg));
      chk($sformatf("t%0d_alu", k),  32'(a_alu),  32'(tbl[k].alu));
      @(posedge clk); #1;
      chk($sformatf("t%0d_retired", k), instr_count - c0, 32'(tbl[k].dcount));
    end

    // Random instruction stream
    for (int r = 0; r < 300; r++) begin
      logic [1:0] op;
      logic [5:0] f;
      logic [3:0] rd;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 5) begin
        op = 2'b00;
        f  = {rnd(), cmds[$urandom_range(0, 5)], rnd()};
      end else begin
        op = (sel < 8) ? 2'b01 : ((sel == 8) ? 2'b10 : 2'b11);
        f  = 6'($urandom_range(0, 63));
      end
      rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      run_instr(op, f, rd, rnd(), $urandom_range(0, 3), $urandom_range(0, 3), n);
    end

    // Reset while a store waits on memory
    do_cycle('{ph: P_F,  rdy: 1'b1}, 2'b01, 6'b011000, 4'd2, 1'b1, 0, -1);
    do_cycle('{ph: P_D,  rdy: 1'b0}, 2'b01, 6'b011000, 4'd2, 1'b1, 1, -1);
    do_cycle('{ph: P_MA, rdy: 1'b0}, 2'b01, 6'b011000, 4'd2, 1'b1, 2, -1);
    do_cycle('{ph: P_MW, rdy: 1'b0}, 2'b01, 6'b011000, 4'd2, 1'b1, 3, -1);
    do_cycle('{ph: P_MW, rdy: 1'b0}, 2'b01, 6'b011000, 4'd2, 1'b1, 4, -1);
    #1 reset = 1'b0;
    #1;
    mcount = '0; pend_ill = 1'b0;
    chk("mid_rst_ctrl", 32'({IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc,
        ALUControl, PCWrite, RegWrite, MemWrite, FlagWrite}),
        32'(exp_out(P_F, 2'b01, 6'b011000, 4'd2, 1'b1, 1'b0)));
    chk("mid_rst_memwrite", 32'(MemWrite), 32'd0);
    chk("mid_rst_count", instr_count, 32'd0);
    chk("mid_rst_count_s", 32'(instr_count_s), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Eight retirements wrap the 3-bit counter back to zero
    for (int w = 0; w < 8; w++) run_instr(2'b00, 6'b101000, 4'd2, 1'b1, 0, 0, n);
    @(posedge clk); #1;
    chk("wrap_s", 32'(instr_count_s), 32'd0);
    chk("wrap", instr_count, 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
